op_handler_dispatcher: RTL

- Sequences the gcode opcode handlers (linear, circular, meta/dummy, ...) behind the parser.
- Accepts one decoded opcode at a time and triggers the selected handler over its trigger/rdy/done handshake.
- Muxes that handler's motor-control and position-update outputs onto the single motors block and position register.
- Includes a watchdog that aborts a handler that never reports done.

---
 rtl/op_handler_dispatcher.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/op_handler_dispatcher.sv
// op_handler_dispatcher: accepts one decoded gcode opcode at a time, triggers the
// matching opcode handler and routes that handler's motor / position traffic
// onto the shared motors block and position register. A watchdog aborts a
// handler that never reports done.
//
// Opcode handshake: an opcode transfers on a clk edge where i_clk_en,
// i_op_valid and o_op_rdy are all high. The parser holds i_op_valid and
// i_op_code stable until that edge; o_op_rdy is high only while idle.
module op_handler_dispatcher #(
    parameter int   NUM_HANDLERS = 4,
    parameter int   OPCODE_W     = 3,
    parameter int   PULSE_W      = 16,
    parameter int   POS_W        = 16,
    parameter logic SERVO_UP     = 1'b0,
    parameter int   TIMEOUT_CYC  = 0
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_clk_en,
    input  logic                            i_op_valid,
    input  logic [OPCODE_W-1:0]             i_op_code,
    output logic                            o_op_rdy,
    output logic                            o_op_done,
    output logic                            o_op_err,
    output logic [NUM_HANDLERS-1:0]         o_hdl_trigger,
    input  logic [NUM_HANDLERS-1:0]         i_hdl_rdy,
    input  logic [NUM_HANDLERS-1:0]         i_hdl_done,
    input  logic [NUM_HANDLERS-1:0]         i_hdl_mot_trigger,
    input  logic [NUM_HANDLERS*PULSE_W-1:0] i_hdl_pulse_x,
    input  logic [NUM_HANDLERS*PULSE_W-1:0] i_hdl_pulse_y,
    input  logic [NUM_HANDLERS-1:0]         i_hdl_servo,
    output logic [NUM_HANDLERS-1:0]         o_hdl_mot_rdy,
    output logic [NUM_HANDLERS-1:0]         o_hdl_mot_done,
    input  logic [NUM_HANDLERS-1:0]         i_hdl_pos_update,
    input  logic [NUM_HANDLERS*POS_W-1:0]   i_hdl_new_x,
    input  logic [NUM_HANDLERS*POS_W-1:0]   i_hdl_new_y,
    output logic                            o_mot_trigger,
    output logic [PULSE_W-1:0]              o_mot_pulse_x,
    output logic [PULSE_W-1:0]              o_mot_pulse_y,
    output logic                            o_mot_servo,
    input  logic                            i_mot_rdy,
    input  logic                            i_mot_done,
    output logic                            o_pos_update,
    output logic [POS_W-1:0]                o_pos_new_x,
    output logic [POS_W-1:0]                o_pos_new_y,
    output logic [2:0]                      o_dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_TRIG     = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_FIN      = 3'd4;

    // Watchdog needs to hold TIMEOUT_CYC; keep one bit when it is disabled.
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [2:0]              r_state;
    logic [OPCODE_W-1:0]     r_sel;
    logic [WD_W-1:0]         r_wdog;
    logic                    r_op_done;
    logic                    r_op_err;
    logic [NUM_HANDLERS-1:0] r_trigger;

    logic                    w_active;
    logic                    w_code_ok;
    logic [NUM_HANDLERS-1:0] w_sel_onehot;
    logic                    w_sel_rdy;
    logic                    w_sel_done;
    logic                    w_sel_mot_trig;
    logic [PULSE_W-1:0]      w_sel_pulse_x;
    logic [PULSE_W-1:0]      w_sel_pulse_y;
    logic                    w_sel_servo;
    logic                    w_sel_pos_update;
    logic [POS_W-1:0]        w_sel_new_x;
    logic [POS_W-1:0]        w_sel_new_y;
    logic [WD_W-1:0]         w_wdog_inc;
    logic                    w_timeout;

    // Extend by one bit so the range check works even when 2**OPCODE_W == NUM_HANDLERS.
    assign w_code_ok  = ({1'b0, i_op_code} < (OPCODE_W + 1)'(NUM_HANDLERS));
    assign w_active   = (r_state != S_IDLE);
    assign w_wdog_inc = r_wdog + 1'b1;
    assign w_timeout  = (TIMEOUT_CYC > 0) && (w_wdog_inc == WD_W'(TIMEOUT_CYC));

    // Pick out the selected handler's flags and slices from the registered index.
    always_comb begin
        w_sel_onehot     = '0;
        w_sel_rdy        = 1'b0;
        w_sel_done       = 1'b0;
        w_sel_mot_trig   = 1'b0;
        w_sel_pulse_x    = '0;
        w_sel_pulse_y    = '0;
        w_sel_servo      = 1'b0;
        w_sel_pos_update = 1'b0;
        w_sel_new_x      = '0;
        w_sel_new_y      = '0;
        for (int i = 0; i < NUM_HANDLERS; i++) begin
            if (r_sel == OPCODE_W'(i)) begin
                w_sel_onehot[i]  = 1'b1;
                w_sel_rdy        = i_hdl_rdy[i];
                w_sel_done       = i_hdl_done[i];
                w_sel_mot_trig   = i_hdl_mot_trigger[i];
                w_sel_pulse_x    = i_hdl_pulse_x[i*PULSE_W +: PULSE_W];
                w_sel_pulse_y    = i_hdl_pulse_y[i*PULSE_W +: PULSE_W];
                w_sel_servo      = i_hdl_servo[i];
                w_sel_pos_update = i_hdl_pos_update[i];
                w_sel_new_x      = i_hdl_new_x[i*POS_W +: POS_W];
                w_sel_new_y      = i_hdl_new_y[i*POS_W +: POS_W];
            end
        end
    end

    // Route the selected handler to the shared blocks; idle values while in IDLE
    // (reset forces IDLE asynchronously, so these go idle immediately too).
    always_comb begin
        o_mot_trigger  = w_active & w_sel_mot_trig;
        o_mot_pulse_x  = w_active ? w_sel_pulse_x : '0;
        o_mot_pulse_y  = w_active ? w_sel_pulse_y : '0;
        o_mot_servo    = w_active ? w_sel_servo : SERVO_UP;
        o_pos_update   = w_active & w_sel_pos_update;
        o_pos_new_x    = w_active ? w_sel_new_x : '0;
        o_pos_new_y    = w_active ? w_sel_new_y : '0;
        o_hdl_mot_rdy  = w_active ? (w_sel_onehot & {NUM_HANDLERS{i_mot_rdy}})  : '0;
        o_hdl_mot_done = w_active ? (w_sel_onehot & {NUM_HANDLERS{i_mot_done}}) : '0;
    end

    // Dispatch FSM; pulse registers clear every clk so they stay one clk wide
    // even when clk_en is low on the following edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_wdog    <= '0;
            r_op_done <= 1'b0;
            r_op_err  <= 1'b0;
            r_trigger <= '0;
        end else begin
            r_op_done <= 1'b0;
            r_op_err  <= 1'b0;
            r_trigger <= '0;
            if (i_clk_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (i_op_valid) begin
                            if (w_code_ok) begin
                                r_sel   <= i_op_code;
                                r_state <= S_WAIT_RDY;
                            end else begin
                                r_op_err <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_RDY: begin
                        if (w_sel_rdy) begin
                            r_state <= S_TRIG;
                        end
                    end
                    S_TRIG: begin
                        r_trigger <= w_sel_onehot;
                        r_wdog    <= '0;
                        r_state   <= S_RUN;
                    end
                    S_RUN: begin
                        r_wdog <= w_wdog_inc;
                        if (w_sel_done) begin
                            r_state <= S_FIN;
                        end else if (w_timeout) begin
                            r_op_err <= 1'b1;
                            r_wdog   <= '0;
                            r_state  <= S_IDLE;
                        end
                    end
                    S_FIN: begin
                        r_op_done <= 1'b1;
                        r_wdog    <= '0;
                        r_state   <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_op_rdy      = (r_state == S_IDLE);
    assign o_op_done     = r_op_done;
    assign o_op_err      = r_op_err;
    assign o_hdl_trigger = r_trigger;
    assign o_dbg_state   = r_state;

endmodule
